sequence_gen: RTL and testbench
===============================

# sequence_gen

Serial pattern transmitter: the transmit end of the single-bit serial sequence interface whose receive end is the sequence detector. Accepts a parallel pattern and repeat count over a valid/ready load handshake, then shifts the pattern MSB-first onto `sequence_out`, one bit per clock, repeating as commanded. Sits upstream of the detector as stimulus source and link driver, and signals completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 4: pattern length in bits (≥2).
- `CNT_W`, 4: width of repeat count.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  pattern/repeat_count valid.
- `load_ready`  out  1  block can accept a load (IDLE only).
- `pattern`  in  WIDTH  bits to send, MSB first.
- `repeat_count`  in  CNT_W  extra repetitions; total sends = repeat_count+1.
- `abort`  in  1  synchronous cancel of transmission in progress.
- `sequence_out`  out  1  serial data bit, registered.
- `out_valid`  out  1  `sequence_out` carries a pattern/parity bit this cycle.
- `done`  out  1  one-cycle pulse after last bit of last repetition.

## Operation
- States: IDLE, SHIFT, PARITY (only with parity feature).
- IDLE: `load_ready`=1, `out_valid`=0, `sequence_out`=0. On `load_valid`&&`load_ready`: capture `pattern` into shadow register and shift register, capture `repeat_count` into rep counter, clear bit counter, go SHIFT.
- SHIFT: `sequence_out`=shift_reg[WIDTH-1], `out_valid`=1; shift left each cycle, bit counter increments 0..WIDTH-1.
- At bit counter = WIDTH-1: if parity enabled -> PARITY; else if rep counter ≠ 0 -> decrement, reload shift reg from shadow, clear bit counter, stay SHIFT (no gap between repetitions); else -> IDLE with `done`=1.
- PARITY: one cycle, `sequence_out` = even parity bit (XOR of pattern), `out_valid`=1; then repeat/finish decision as above.
- `load_valid` while not IDLE: ignored, no capture, no error.
- `abort`=1 in SHIFT/PARITY: next cycle IDLE, `out_valid`=0, `sequence_out`=0, `done` NOT pulsed. `abort` in IDLE: no effect; abort has priority over a same-cycle load.
- Counters: bit counter ceil(log2(WIDTH)) bits, never wraps past WIDTH-1; rep counter CNT_W bits, repeat_count = 2^CNT_W−1 yields 2^CNT_W sends, no wrap.

## Timing
- Reset (async assert, sync deassert expected upstream): state IDLE, `load_ready`=1, `sequence_out`=0, `out_valid`=0, `done`=0, all counters 0.
- Reset mid-transmission: outputs return to reset values immediately; no `done`.
- Load accepted on edge N -> first bit (pattern MSB) valid cycle N+1; last bit of single send at N+WIDTH (N+WIDTH+1 with parity).
- `done` and `load_ready` both high in the cycle after last bit; a load in that cycle is accepted, so back-to-back commands have exactly one idle cycle between bit streams.
- All outputs registered; no combinational input-to-output path except none (`load_ready` decodes state only).

## Configuration
- `SEQ_GEN_PARITY_EN` defined: PARITY state present; each repetition is WIDTH+1 bits, last bit is even parity of pattern.
- Undefined: no PARITY state, each repetition exactly WIDTH bits; state encoding reduces to IDLE/SHIFT.

## Structure
- Shared package `seq_pkg`: state enum (IDLE, SHIFT, PARITY) with fixed encodings, default WIDTH/CNT_W constants, shared with the detector and benches.
- One sub-module natural: `seq_shift_reg` (loadable MSB-first shift register with shadow reload); FSM and counters stay in `sequence_gen`.

## Test plan
- pattern=4'b1010, repeat_count=0, load at cycle 0 -> `sequence_out` 1,0,1,0 on cycles 1-4 with `out_valid`=1; `done`=1 cycle 5 only; detector downstream fires once.
- pattern=4'b1100, repeat_count=2 -> 12 contiguous valid bits 110011001100, single `done` after bit 12.
- Parity build, pattern=4'b1011, repeat_count=0 -> 1,0,1,1,1 (parity=1) on cycles 1-5, `done` cycle 6.
- Load pattern 4'b1111, assert `abort` at cycle 2 (with a new `load_valid`) -> cycle 3 `out_valid`=0, `sequence_out`=0, no `done`, new load not accepted; `load_ready`=1 from cycle 3.
- `load_valid` held during transmission with different pattern -> ignored; load re-presented in `done` cycle accepted, its first bit on next cycle.
- Drop `reset` low at cycle 3 of a send -> all outputs to reset values asynchronously; after release, `load_ready`=1 and fresh load transmits correctly.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link: FSM state encoding and default
// pattern/repeat widths, used by the generator, the detector and their benches.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register with a shadow copy of the pattern, so that each
// repetition can restart from the original pattern without a gap.
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb_d,
  output logic             parity
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  always_comb begin
    data_d   = data_q;
    shadow_d = shadow_q;
    if (load) begin
      data_d   = din;
      shadow_d = din;
    end else if (reload) begin
      data_d = shadow_q;
    end else if (shift) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  // The bit that will be on the line next cycle, so the top can register its output.
  assign msb_d  = data_d[WIDTH-1];
  assign parity = ^shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: shifts a loaded pattern MSB-first, repeat_count+1 times,
// then pulses done. Define SEQ_GEN_PARITY_EN to append an even-parity bit per repetition.
module sequence_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_count,
  input  logic             abort,
  output logic             sequence_out,
  output logic             out_valid,
  output logic             done,
  output state_e           state_dbg
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             seq_out_q, seq_out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             load_en, reload_en, shift_en, end_of_rep;
  logic             msb_d, parity;

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clock),
    .rst_n (reset),
    .load  (load_en),
    .reload(reload_en),
    .shift (shift_en),
    .din   (pattern),
    .msb_d (msb_d),
    .parity(parity)
  );

  // Load handshake: a command transfers on a rising edge where load_valid && load_ready
  // && !abort; load_ready is high only in IDLE and load_valid is ignored elsewhere.
  assign load_ready = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    rep_d      = rep_q;
    load_en    = 1'b0;
    reload_en  = 1'b0;
    shift_en   = 1'b0;
    done_d     = 1'b0;
    end_of_rep = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid && !abort) begin
          load_en = 1'b1;
          rep_d   = repeat_count;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          bit_d   = '0;
          rep_d   = '0;
        end else if (bit_q == LAST_BIT) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = PARITY;
          bit_d   = '0;
`else
          end_of_rep = 1'b1;
`endif
        end else begin
          shift_en = 1'b1;
          bit_d    = bit_q + BIT_W'(1);
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        if (abort) begin
          state_d = IDLE;
          bit_d   = '0;
          rep_d   = '0;
        end else begin
          end_of_rep = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Repeat without a gap by reloading from the shadow copy, or finish with done.
    if (end_of_rep) begin
      bit_d = '0;
      if (rep_q != '0) begin
        rep_d     = rep_q - CNT_W'(1);
        reload_en = 1'b1;
        state_d   = SHIFT;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    out_valid_d = (state_d != IDLE);
    if (state_d == SHIFT)       seq_out_d = msb_d;
    else if (state_d == PARITY) seq_out_d = parity;
    else                        seq_out_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      rep_q       <= '0;
      seq_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      rep_q       <= rep_d;
      seq_out_q   <= seq_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign sequence_out = seq_out_q;
  assign out_valid    = out_valid_q;
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sequence_gen.sv
// Bench for sequence_gen: directed and random commands, scored against a queue of
// expected line bits built from the pattern/repeat rules.
module tb_sequence_gen;
  import seq_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int C = DEF_CNT_W;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] pattern = '0;
  logic [C-1:0] repeat_count = '0;
  logic         abort = 1'b0;
  logic         sequence_out;
  logic         out_valid;
  logic         done;
  state_e       state_dbg;

  sequence_gen #(.WIDTH(W), .CNT_W(C)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .pattern     (pattern),
    .repeat_count(repeat_count),
    .abort       (abort),
    .sequence_out(sequence_out),
    .out_valid   (out_valid),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // scoreboard: each entry is {last_bit_of_command, line_bit}
  logic [1:0] exp_q[$];
  logic       done_exp = 1'b0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: (rep+1) copies of the pattern MSB-first, plus parity when enabled
  task automatic push_command(input logic [W-1:0] pat, input logic [C-1:0] rep);
    int n;
    n = int'(rep) + 1;
    for (int r = 0; r < n; r++) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back({1'b0, pat[i]});
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back({1'b0, ^pat});
`endif
    end
    exp_q[exp_q.size() - 1][1] = 1'b1;
  endtask

  // driver: present inputs for one cycle, then update the model for the edge
  task automatic drive(input logic lv, input logic [W-1:0] pat, input logic [C-1:0] rep,
                       input logic ab, output logic acc);
    logic busy;
    busy         = (exp_q.size() != 0);
    load_valid   = lv;
    pattern      = pat;
    repeat_count = rep;
    abort        = ab;
    @(posedge clock);
    #1;
    acc = 1'b0;
    if (ab && busy) begin
      exp_q.delete();
      done_exp = 1'b0;
    end else if (lv && !busy && !ab) begin
      push_command(pat, rep);
      acc = 1'b1;
    end
    load_valid = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, acc);
  endtask

  // monitor
  always @(negedge clock) begin
    if (reset) begin
      check("load_ready", {31'b0, load_ready}, {31'b0, exp_q.size() == 0});
      check("done", {31'b0, done}, {31'b0, done_exp});
      done_exp = 1'b0;
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0) begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("sequence_out", {31'b0, sequence_out}, {31'b0, e[0]});
        if (e[1]) done_exp = 1'b1;
      end else if (!out_valid) begin
        check("sequence_out_idle", {31'b0, sequence_out}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sequence_out"}, {31'b0, sequence_out}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_load_ready"}, {31'b0, load_ready}, 32'd1);
  endtask

  initial begin
    logic acc;
    int   accepts;
    int   budget;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;

    // single send, then three repetitions
    drive(1'b1, 4'b1010, 4'd0, 1'b0, acc);
    check("accept_1010", {31'b0, acc}, 32'd1);
    idle(7);
    drive(1'b1, 4'b1100, 4'd2, 1'b0, acc);
    idle(16);

    // abort in the second bit cycle with a competing load
    drive(1'b1, 4'b1111, 4'd0, 1'b0, acc);
    idle(1);
    drive(1'b1, 4'b0101, 4'd0, 1'b1, acc);
    check("abort_blocks_load", {31'b0, acc}, 32'd0);
    idle(4);

    // load_valid held through a transmission; second load lands in the done cycle
    accepts = 0;
    for (int i = 0; i < 30 && accepts < 2; i++) begin
      drive(1'b1, (accepts == 0) ? 4'b0110 : 4'b1001, 4'd1, 1'b0, acc);
      if (acc) accepts++;
    end
    check("held_load_accepts", accepts, 2);
    idle(12);

    // reset dropped mid-send
    drive(1'b1, 4'b1011, 4'd1, 1'b0, acc);
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    done_exp = 1'b0;
    check_reset_outputs("midrst");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b1, 4'b0111, 4'd0, 1'b0, acc);
    check("accept_after_reset", {31'b0, acc}, 32'd1);
    idle(6);

    // random traffic, including full-range repeat counts and aborts
    for (int i = 0; i < 500; i++) begin
      logic         lv, ab;
      logic [W-1:0] pat;
      logic [C-1:0] rep;
      lv  = ($urandom_range(0, 2) == 0);
      pat = W'($urandom_range(0, (1 << W) - 1));
      rep = ($urandom_range(0, 9) == 0) ? {C{1'b1}} : C'($urandom_range(0, 2));
      ab  = (exp_q.size() != 0) && ($urandom_range(0, 40) == 0);
      drive(lv, pat, rep, ab, acc);
    end

    // drain with a bounded budget
    budget = 0;
    while ((exp_q.size() != 0 || done_exp) && budget < 200) begin
      idle(1);
      budget++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
